// File: rtl/framebuffer_scanner_pkg.sv
// Shared definitions for the frame RAM, its write-side loader and the read-side scanner.
package framebuffer_scanner_pkg;

  localparam int unsigned DefaultColumns     = 64;
  localparam int unsigned DefaultRowPairs    = 16;
  localparam int unsigned DefaultDwellCycles = 256;

  localparam int unsigned RamAddrW = 11;
  localparam int unsigned BankBit  = 10;

  // Pixel bit positions within a RAM word and within the panel data pair {R2, R1}.
  localparam int unsigned PixUpper = 0;
  localparam int unsigned PixLower = 1;

  typedef enum logic [1:0] {
    StShift = 2'd0,
    StBlank = 2'd1,
    StLatch = 2'd2,
    StDwell = 2'd3
  } scan_state_e;

  function automatic logic [RamAddrW-1:0] ram_addr(input logic bank,
                                                   input logic [BankBit-1:0] offset);
    return {bank, offset};
  endfunction

endpackage

// File: rtl/framebuffer_scanner.sv
// HUB75 scanner: reads one bank of the frame RAM row-pair by row-pair, shifts it into the
// panel, then blanks, latches, dwells, and swaps banks on request at frame boundaries.
module framebuffer_scanner
  import framebuffer_scanner_pkg::*;
#(
  parameter int unsigned COLUMNS      = DefaultColumns,
  parameter int unsigned ROW_PAIRS    = DefaultRowPairs,
  parameter int unsigned DWELL_CYCLES = DefaultDwellCycles
) (
  input  logic                         Clock,
  input  logic                         Reset,
  output logic [RamAddrW-1:0]          RamAddress,
  output logic                         RamClockEn,
  input  logic [1:0]                   RamData,
  output logic [1:0]                   PanelData,
  output logic                         PanelClock,
  output logic                         PanelLatch,
  output logic                         PanelOE_n,
  output logic [$clog2(ROW_PAIRS)-1:0] RowAddress,
  input  logic                         BankSwapReq,
  output logic                         BankSwapAck,
  output logic                         ActiveBank
);

  localparam int unsigned ColW     = $clog2(COLUMNS);
  localparam int unsigned RowW     = $clog2(ROW_PAIRS);
  localparam int unsigned ShiftLen = 2 * COLUMNS + 2;
  localparam int unsigned CntW     = $clog2(ShiftLen);
  localparam int unsigned OnW      = $clog2(DWELL_CYCLES) + 1;
  localparam int          DwellThr = int'(DWELL_CYCLES) - int'(ShiftLen);

  localparam logic [CntW-1:0] ShiftLast = CntW'(ShiftLen - 1);
  localparam logic [CntW-1:0] IssueEnd  = CntW'(2 * COLUMNS);
  localparam logic [CntW-1:0] ClkFirst  = CntW'(2);
  localparam logic [RowW-1:0] RowLast   = RowW'(ROW_PAIRS - 1);
  localparam logic [OnW-1:0]  OnMax     = '1;
  // Last DWELL cycle is the one whose on-count, including itself, reaches the threshold.
  localparam logic [OnW-1:0]  DwellLast = (DwellThr > 1) ? OnW'(DwellThr - 1) : '0;

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RowW-1:0] row_q, row_d;
  logic [RowW-1:0] row_addr_q, row_addr_d;
  logic [OnW-1:0]  on_cnt_q, on_cnt_d;
  logic            bank_q, bank_d;
  logic            ack_q, ack_d;
  logic [1:0]      pdata_q, pdata_d;
  logic            pclk_q, pclk_d;
  logic            latch_q, latch_d;
  logic            oe_n_q, oe_n_d;
  logic [ColW-1:0] col;

  // Each column occupies two cycles: address on the even one, data returns on the odd one.
  always_comb begin
    col = '0;
    if (state_q == StShift && cnt_q < IssueEnd) begin
      col = cnt_q[ColW:1];
    end
  end

  assign RamAddress  = ram_addr(bank_q, BankBit'({row_q, col}));
  assign RamClockEn  = 1'b1;
  assign PanelData   = pdata_q;
  assign PanelClock  = pclk_q;
  assign PanelLatch  = latch_q;
  assign PanelOE_n   = oe_n_q;
  assign RowAddress  = row_addr_q;
  assign BankSwapAck = ack_q;
  assign ActiveBank  = bank_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    bank_d     = bank_q;
    pdata_d    = pdata_q;
    oe_n_d     = oe_n_q;
    ack_d      = 1'b0;
    pclk_d     = 1'b0;
    latch_d    = 1'b0;
    on_cnt_d   = on_cnt_q;
    if (!oe_n_q && on_cnt_q != OnMax) begin
      on_cnt_d = on_cnt_q + 1'b1;
    end

    unique case (state_q)
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[0] && cnt_q < IssueEnd) begin
          pdata_d[PixUpper] = RamData[PixUpper];
          pdata_d[PixLower] = RamData[PixLower];
        end
        // Rising edge one cycle after the data register updates.
        if (!cnt_q[0] && cnt_q >= ClkFirst && cnt_q <= IssueEnd) begin
          pclk_d = 1'b1;
        end
        if (cnt_q == ShiftLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          oe_n_d  = 1'b1;
        end
      end
      StBlank: begin
        state_d    = StLatch;
        latch_d    = 1'b1;
        row_addr_d = row_q;
      end
      StLatch: begin
        state_d  = StDwell;
        oe_n_d   = 1'b0;
        on_cnt_d = '0;
        row_d    = row_q + 1'b1;
        if (row_q == RowLast && BankSwapReq) begin
          bank_d = ~bank_q;
          ack_d  = 1'b1;
        end
      end
      StDwell: begin
        if (on_cnt_q >= DwellLast) begin
          state_d = StShift;
        end
      end
      default: state_d = StShift;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StShift;
      cnt_q      <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
      on_cnt_q   <= '0;
      bank_q     <= 1'b0;
      ack_q      <= 1'b0;
      pdata_q    <= '0;
      pclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      row_addr_q <= row_addr_d;
      on_cnt_q   <= on_cnt_d;
      bank_q     <= bank_d;
      ack_q      <= ack_d;
      pdata_q    <= pdata_d;
      pclk_q     <= pclk_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Scoreboard bench for framebuffer_scanner: queued pixel/address and latch-row expectations,
// plus directed checks of blanking, dwell length, bank swap and mid-scan reset.
module tb_framebuffer_scanner;

  logic        Clock;
  logic        Reset;
  logic [10:0] RamAddress;
  logic        RamClockEn;
  logic [1:0]  RamData;
  logic [1:0]  PanelData;
  logic        PanelClock;
  logic        PanelLatch;
  logic        PanelOE_n;
  logic [3:0]  RowAddress;
  logic        BankSwapReq;
  logic        BankSwapAck;
  logic        ActiveBank;

  // Second instance with a short dwell; only its OE timing is examined.
  logic [10:0] RamAddress2;
  logic        RamClockEn2;
  logic [1:0]  RamData2;
  logic [1:0]  PanelData2;
  logic        PanelClock2;
  logic        PanelLatch2;
  logic        PanelOE_n2;
  logic [3:0]  RowAddress2;
  logic        BankSwapAck2;
  logic        ActiveBank2;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  bit done2 = 0;

  typedef struct packed {
    logic [10:0] addr;
    logic [1:0]  data;
  } pix_t;

  pix_t pix_q[$];
  int   lat_q[$];
  logic [1:0] mem [0:2047];
  logic [1:0] ram_q;

  framebuffer_scanner dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RamAddress  (RamAddress),
    .RamClockEn  (RamClockEn),
    .RamData     (RamData),
    .PanelData   (PanelData),
    .PanelClock  (PanelClock),
    .PanelLatch  (PanelLatch),
    .PanelOE_n   (PanelOE_n),
    .RowAddress  (RowAddress),
    .BankSwapReq (BankSwapReq),
    .BankSwapAck (BankSwapAck),
    .ActiveBank  (ActiveBank)
  );

  framebuffer_scanner #(
    .DWELL_CYCLES (10)
  ) dut_short (
    .Clock       (Clock),
    .Reset       (Reset),
    .RamAddress  (RamAddress2),
    .RamClockEn  (RamClockEn2),
    .RamData     (RamData2),
    .PanelData   (PanelData2),
    .PanelClock  (PanelClock2),
    .PanelLatch  (PanelLatch2),
    .PanelOE_n   (PanelOE_n2),
    .RowAddress  (RowAddress2),
    .BankSwapReq (1'b0),
    .BankSwapAck (BankSwapAck2),
    .ActiveBank  (ActiveBank2)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // Pixel pattern depends on column, row and bank so misaddressing shows up in the data.
  function automatic logic [1:0] pat(input logic [10:0] a);
    return a[1:0] ^ a[7:6] ^ {2{a[10]}};
  endfunction

  initial begin
    for (int a = 0; a < 2048; a++) begin
      mem[a] = pat(11'(a));
    end
  end

  always @(posedge Clock) begin
    if (RamClockEn) ram_q <= mem[RamAddress];
  end
  assign RamData = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_row(input int r, input logic b);
    pix_t e;
    for (int k = 0; k < 64; k++) begin
      e.addr = {b, 4'(r), 6'(k)};
      e.data = pat(e.addr);
      pix_q.push_back(e);
    end
    lat_q.push_back(r);
  endtask

  task automatic wait_latch();
    int n;
    n = 0;
    @(negedge Clock);
    while (PanelLatch !== 1'b1 && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    if (PanelLatch !== 1'b1) fail("latch_timeout");
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ram_addr"},   32'(RamAddress),  0);
    chk({tag, "_ram_clk_en"}, 32'(RamClockEn),  1);
    chk({tag, "_panel_data"}, 32'(PanelData),   0);
    chk({tag, "_panel_clk"},  32'(PanelClock),  0);
    chk({tag, "_latch"},      32'(PanelLatch),  0);
    chk({tag, "_oe_n"},       32'(PanelOE_n),   1);
    chk({tag, "_row_addr"},   32'(RowAddress),  0);
    chk({tag, "_ack"},        32'(BankSwapAck), 0);
    chk({tag, "_bank"},       32'(ActiveBank),  0);
  endtask

  // Monitor: on each panel clock rise, the shown pixel must match the queued expectation and
  // the RAM address three cycles earlier must be the one that pixel came from.
  initial begin : pix_mon
    logic pclk_prev;
    logic [10:0] h0, h1, h2;
    pix_t e;
    pclk_prev = 1'b0;
    h0 = '0;
    h1 = '0;
    h2 = '0;
    forever begin
      @(negedge Clock);
      if (!Reset && PanelClock === 1'b1 && !pclk_prev) begin
        if (pix_q.size() == 0) begin
          fail("pix_underflow");
        end else begin
          e = pix_q.pop_front();
          chk("pix_addr", 32'(h2), 32'(e.addr));
          chk("pix_data", 32'(PanelData), 32'(e.data));
        end
      end
      pclk_prev = PanelClock;
      h2 = h1;
      h1 = h0;
      h0 = RamAddress;
    end
  end

  initial begin : lat_mon
    int exp_row;
    forever begin
      @(negedge Clock);
      if (!Reset && PanelLatch === 1'b1) begin
        if (lat_q.size() == 0) begin
          fail("latch_underflow");
        end else begin
          exp_row = lat_q.pop_front();
          chk("latch_row", 32'(RowAddress), exp_row);
        end
      end
      if (!Reset && BankSwapAck === 1'b1) ack_cnt++;
    end
  end

  initial begin : short_dwell
    int lows;
    int n;
    RamData2 = 2'b00;
    for (int row = 0; row < 2; row++) begin
      n = 0;
      @(negedge Clock);
      while ((Reset || PanelOE_n2 !== 1'b0) && n < 2000) begin
        @(negedge Clock);
        n++;
      end
      if (n >= 2000) fail("short_dwell_timeout");
      lows = 0;
      while (PanelOE_n2 === 1'b0 && lows < 2000) begin
        lows++;
        @(negedge Clock);
      end
      chk("short_dwell_oe_low", lows, 131);
    end
    done2 = 1;
  end

  initial begin : main
    int bad;
    int lows;
    int n;
    Reset       = 1'b1;
    BankSwapReq = 1'b0;
    for (int r = 0; r < 16; r++) push_row(r, 1'b0);
    for (int r = 0; r < 16; r++) push_row(r, 1'b1);
    push_row(0, 1'b0);

    repeat (3) @(negedge Clock);
    check_reset("por");
    Reset = 1'b0;

    // First SHIFT: panel stays dark.
    bad = 0;
    for (int c = 0; c < 130; c++) begin
      if (PanelOE_n !== 1'b1) bad++;
      @(negedge Clock);
    end
    chk("first_shift_oe_off", bad, 0);
    chk("blank_oe_n", 32'(PanelOE_n), 1);
    chk("blank_latch", 32'(PanelLatch), 0);
    @(negedge Clock);
    chk("latch_pulse", 32'(PanelLatch), 1);
    chk("latch_row0", 32'(RowAddress), 0);
    @(negedge Clock);
    chk("dwell_oe_n", 32'(PanelOE_n), 0);
    chk("dwell_latch", 32'(PanelLatch), 0);
    lows = 0;
    while (PanelOE_n === 1'b0 && lows < 1000) begin
      lows++;
      @(negedge Clock);
    end
    chk("row_oe_low_cycles", lows, 256);

    // Rows 1 and 2 latched; request rises while row 3 is scanned.
    wait_latch();
    wait_latch();
    BankSwapReq = 1'b1;
    bad = 0;
    for (int r = 3; r < 16; r++) begin
      wait_latch();
      if (BankSwapAck !== 1'b0 || ActiveBank !== 1'b0) bad++;
    end
    chk("swap_held_off", bad, 0);
    @(negedge Clock);
    chk("swap_ack", 32'(BankSwapAck), 1);
    chk("swap_bank", 32'(ActiveBank), 1);
    chk("swap_addr", 32'(RamAddress), 'h400);
    @(negedge Clock);
    chk("swap_ack_pulse", 32'(BankSwapAck), 0);

    // Request left high: bank holds for a whole frame, then swaps again.
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      wait_latch();
      if (BankSwapAck !== 1'b0 || ActiveBank !== 1'b1) bad++;
    end
    chk("no_early_second_swap", bad, 0);
    @(negedge Clock);
    chk("frame2_ack", 32'(BankSwapAck), 1);
    chk("frame2_bank", 32'(ActiveBank), 0);
    chk("wrap_addr", 32'(RamAddress), 0);
    BankSwapReq = 1'b0;

    // 126 DWELL cycles, then SHIFT cycle 0 of row 0.
    repeat (126) @(negedge Clock);
    chk("shift_start_addr", 32'(RamAddress), 0);
    chk("shift_oe_lit", 32'(PanelOE_n), 0);
    repeat (60) @(negedge Clock);
    Reset = 1'b1;
    pix_q.delete();
    lat_q.delete();
    @(negedge Clock);
    check_reset("mid");
    Reset = 1'b0;
    push_row(0, 1'b0);
    push_row(1, 1'b0);
    wait_latch();
    wait_latch();
    chk("pix_queue_drained", pix_q.size(), 0);
    chk("latch_queue_drained", lat_q.size(), 0);
    chk("ack_pulse_count", ack_cnt, 2);

    n = 0;
    while (!done2 && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    if (!done2) fail("short_dwell_not_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanner.md
# framebuffer_scanner

Read-side consumer of the 2-bit × 2048 dual-port frame RAM. Walks one bank of the RAM row-pair by row-pair, shifts each column's two pixel bits (upper-half, lower-half) into a HUB75-style panel, then blanks, latches, advances the row address and dwells. Owns the double-buffer bank select: the writer fills the inactive bank, and a request/acknowledge handshake swaps banks only at frame boundaries.

## Interface
- COLUMNS, 64, columns per panel row; power of 2.
- ROW_PAIRS, 16, scan rows (1/ROW_PAIRS scan); power of 2; 2·COLUMNS·ROW_PAIRS ≤ 2048.
- DWELL_CYCLES, 256, minimum total cycles OE is asserted per row (shift time counts toward it).

Ports:
- Clock  in  1  single clock; drives the RAM read port (ClockB) too.
- Reset  in  1  synchronous, active-high.
- RamAddress  out  11  RAM read address {bank, row, col}: bank is bit 10, row·COLUMNS+col in bits 9:0.
- RamClockEn  out  1  RAM read clock enable; constant 1 when out of reset.
- RamData  in  2  RAM QB; bit1 = lower-half pixel, bit0 = upper-half pixel.
- PanelData  out  2  {R2, R1} to panel.
- PanelClock  out  1  panel shift clock; panel samples on rising edge.
- PanelLatch  out  1  panel latch strobe, active high.
- PanelOE_n  out  1  panel output enable, active low.
- RowAddress  out  log2(ROW_PAIRS)  panel row select.
- BankSwapReq  in  1  level; writer has finished the inactive bank.
- BankSwapAck  out  1  one-cycle pulse when the swap takes effect.
- ActiveBank  out  1  bank currently being scanned; writer targets ~ActiveBank.

## Operation
- States: SHIFT → BLANK → LATCH → DWELL → SHIFT.
- SHIFT: COLUMNS columns of row r are issued from bank ActiveBank. PanelOE_n keeps its previous value (the previous row stays lit).
- BLANK: 1 cycle. PanelOE_n = 1.
- LATCH: 1 cycle. PanelLatch = 1 and RowAddress ← r.
  - If r = ROW_PAIRS−1 and BankSwapReq = 1: ActiveBank toggles and BankSwapAck = 1 on the following cycle.
  - r ← (r+1) mod ROW_PAIRS; wraps 15→0.
- DWELL: PanelOE_n = 0. Stay until on-counter (reset on leaving LATCH) ≥ DWELL_CYCLES − 130. If that value is ≤ 0, DWELL lasts exactly 1 cycle. Then go to SHIFT.
- On-counter counts cycles with PanelOE_n = 0 across DWELL and the following SHIFT. Width ≥ clog2(DWELL_CYCLES)+1, saturating.
- BankSwapReq asserted mid-frame is held off until the last-row LATCH. Deasserted before then: no swap. Still high after the Ack: no second swap until the next frame end. The writer must drop the request on Ack.
- First frame after reset: PanelOE_n stays 1 until the first DWELL.

## Timing
- RAM read latency is 1 cycle: an address presented during cycle t yields RamData valid during t+1.
- Cycle n is counted from SHIFT entry.
- Column k: RamAddress presented in cycle 2k.
- RamData registered into PanelData at the end of cycle 2k+1.
- PanelClock high in cycle 2k+3 only, low otherwise. Data is stable ≥1 cycle before the rising edge and during the high cycle.
- SHIFT length = 2·COLUMNS+2 cycles (130 at defaults); last PanelClock high in cycle 129.
- Reset values: RamAddress 0, RamClockEn 1, PanelData 0, PanelClock 0, PanelLatch 0, PanelOE_n 1, RowAddress 0, BankSwapAck 0, ActiveBank 0, r 0, state SHIFT.
- Reset mid-operation: all outputs return to reset values on the next edge. A pending swap is dropped.

## Structure
- Shared package: COLUMNS/ROW_PAIRS defaults, RAM address width (11), bank bit index (10), scanner state enum, pixel bit ordering constants. The write-side loader uses the same package.
- Single module, no sub-modules. The frame RAM is instantiated at top level, next to this block and the writer.

## Test plan
- Post-reset, behavioral RAM model with bank0 col k = k[1:0]: first SHIFT gives RamAddress 0..63 in even cycles, PanelData = k[1:0] sampled on 64 PanelClock rises, PanelOE_n = 1 throughout.
- Full row cycle: BLANK 1 cycle with OE_n = 1, then PanelLatch pulse with RowAddress = 0, then OE_n = 0 for exactly 256 cycles before the next BLANK.
- DWELL_CYCLES = 10: DWELL lasts 1 cycle; OE low time = 131 cycles per row.
- Row wrap: after row 15 is latched, the next RamAddress = {bank, 0, 0}.
- Swap: BankSwapReq raised during row 3 → Ack pulse only after the row-15 LATCH; ActiveBank 0→1; next RamAddress = 0x400. Req held high → no second toggle until the following frame end.
- Reset asserted at cycle 60 of SHIFT: next cycle all outputs at reset values; scan restarts at address 0, row 0.
